// File: rtl/input_handler.sv
// Host byte-stream deframer: sync byte + 12 big-endian bytes -> command/address/data words.
// Optional trailing checksum byte enabled by defining INPUT_HANDLER_CHECKSUM_EN.
`timescale 1ns/1ps
module input_handler #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hCD,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        master_ready,
    output logic        in_ready,
    output logic [31:0] in_command,
    output logic [31:0] in_address,
    output logic [31:0] in_data,
    output logic        frame_error,
    output logic [7:0]  error_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO  = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE   = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 32'd1);
    localparam logic                     TMO_EN    = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [3:0]               LAST_IDX  = 4'd11;

    state_t                   state_q, state_d;
    logic [95:0]              shift_q, shift_d;
    logic [3:0]               idx_q, idx_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [31:0]              cmd_q, cmd_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic                     in_ready_q, in_ready_d;
    logic                     frame_error_q, frame_error_d;
    logic [7:0]               err_cnt_q, err_cnt_d;
`ifdef INPUT_HANDLER_CHECKSUM_EN
    logic [7:0]               sum_q, sum_d;
`endif

    logic accept_s;
    logic timeout_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign byte_ready = (state_q != ST_WAIT);
    assign accept_s   = byte_valid && byte_ready;
    // A byte arriving on the would-be timeout cycle suppresses the timeout.
    assign timeout_s  = TMO_EN && !accept_s && (tmo_q == TMO_LIMIT);

    assign in_ready    = in_ready_q;
    assign in_command  = cmd_q;
    assign in_address  = addr_q;
    assign in_data     = data_q;
    assign frame_error = frame_error_q;
    assign error_count = err_cnt_q;

    // Next-state and next-output computation for the deframer.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        in_ready_d    = 1'b0;
        frame_error_d = 1'b0;
        err_cnt_d     = err_cnt_q;
`ifdef INPUT_HANDLER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (byte_data == SYNC_BYTE)) begin
                    state_d = ST_COLLECT;
                    idx_d   = 4'd0;
                    tmo_d   = TMO_ZERO;
`ifdef INPUT_HANDLER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    shift_d = {shift_q[87:0], byte_data};
                    tmo_d   = TMO_ZERO;
`ifdef INPUT_HANDLER_CHECKSUM_EN
                    sum_d   = sum_q + byte_data;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef INPUT_HANDLER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_WAIT;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (timeout_s) begin
                    state_d       = ST_IDLE;
                    frame_error_d = 1'b1;
                    err_cnt_d     = sat_inc(err_cnt_q);
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
`ifdef INPUT_HANDLER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    tmo_d = TMO_ZERO;
                    if (byte_data == sum_q) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d       = ST_IDLE;
                        frame_error_d = 1'b1;
                        err_cnt_d     = sat_inc(err_cnt_q);
                    end
                end else if (timeout_s) begin
                    state_d       = ST_IDLE;
                    frame_error_d = 1'b1;
                    err_cnt_d     = sat_inc(err_cnt_q);
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
`endif
            ST_WAIT: begin
                if (master_ready) begin
                    cmd_d      = shift_q[95:64];
                    addr_d     = shift_q[63:32];
                    data_d     = shift_q[31:0];
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shift_q       <= 96'd0;
            idx_q         <= 4'd0;
            tmo_q         <= TMO_ZERO;
            cmd_q         <= 32'd0;
            addr_q        <= 32'd0;
            data_q        <= 32'd0;
            in_ready_q    <= 1'b0;
            frame_error_q <= 1'b0;
            err_cnt_q     <= 8'd0;
`ifdef INPUT_HANDLER_CHECKSUM_EN
            sum_q         <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            in_ready_q    <= in_ready_d;
            frame_error_q <= frame_error_d;
            err_cnt_q     <= err_cnt_d;
`ifdef INPUT_HANDLER_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

endmodule
